// File: rtl/aes_loader_pkg.sv
// Shared types and constants for the AES byte-serial loader front-end.
package aes_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RX_KEY,
        RX_PT,
        LAUNCH,
        WAIT_HI,
        WAIT_LO,
        TX_CT
    } state_e;

    localparam logic [7:0] CMD_KEY = 8'h6B;
    localparam logic [7:0] CMD_PT  = 8'h70;
    localparam logic [7:0] CMD_CLR = 8'h63;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned PT_BYTES = 16;
    localparam int unsigned CT_BYTES = 16;
    localparam int unsigned KEY_W    = 256;
    localparam int unsigned PT_W     = PT_BYTES * BYTE_W;
    localparam int unsigned CT_W     = CT_BYTES * BYTE_W;

endpackage

// File: rtl/aes_loader_shreg.sv
// MSB-first byte shift register: new bytes enter at the LSB end and move up.
module aes_loader_shreg
    import aes_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              shift,
    input  logic [BYTE_W-1:0] din,
    output logic [WIDTH-1:0]  q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[WIDTH-BYTE_W-1:0], din};
        end
    end

endmodule

// File: rtl/aes_byte_loader.sv
// Byte-serial command front-end for the AES core: loads key/plaintext, launches, returns ciphertext.
// Optional build macro AES_LOADER_TIMEOUT_EN aborts a stuck WAIT after TIMEOUT_CYC cycles.
module aes_byte_loader
    import aes_loader_pkg::*;
#(
    parameter int unsigned KEY_BYTES   = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic [255:0]  key_o,
    output logic [127:0]  pt_o,
    output logic          load_o,
    input  logic          busy_i,
    input  logic [127:0]  ct_i,
    output logic          err_o
);

    localparam int unsigned KEY_SR_W = KEY_BYTES * BYTE_W;
    localparam int unsigned KEY_PAD  = KEY_W - KEY_SR_W;

    if (KEY_BYTES < 16 || KEY_BYTES > 32 || TIMEOUT_CYC < 2) begin : g_cfg_err
        $error("aes_byte_loader: KEY_BYTES must be 16..32 and TIMEOUT_CYC >= 2");
    end

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             rx_fire, tx_fire;
    logic             cnt_inc;
    logic             err_set, err_clr;
    logic             key_clr, key_shift;
    logic             pt_clr, pt_shift;
    logic             ct_load, ct_shift;
    logic [KEY_SR_W-1:0] key_q;
    logic [CT_W-1:0]     ct_q;

    assign rx_fire = rx_valid_i & rx_ready_o;
    assign tx_fire = tx_valid_o & tx_ready_i;

`ifdef AES_LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // Counts consecutive cycles spent waiting on the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == WAIT_HI || state == WAIT_LO) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        key_clr   = 1'b0;
        key_shift = 1'b0;
        pt_clr    = 1'b0;
        pt_shift  = 1'b0;
        ct_load   = 1'b0;
        ct_shift  = 1'b0;
        case (state)
            IDLE: state_nxt = CMD;
            CMD: begin
                if (rx_fire) begin
                    case (rx_data_i)
                        CMD_KEY: begin
                            state_nxt = RX_KEY;
                            key_clr   = 1'b1;
                        end
                        CMD_PT: begin
                            state_nxt = RX_PT;
                            pt_clr    = 1'b1;
                        end
                        CMD_CLR: err_clr = 1'b1;
                        default: err_set = 1'b1;
                    endcase
                end
            end
            RX_KEY: begin
                if (rx_fire) begin
                    key_shift = 1'b1;
                    cnt_inc   = 1'b1;
                    if (cnt == CNT_W'(KEY_BYTES - 1)) state_nxt = CMD;
                end
            end
            RX_PT: begin
                if (rx_fire) begin
                    pt_shift = 1'b1;
                    cnt_inc  = 1'b1;
                    if (cnt == CNT_W'(PT_BYTES - 1)) state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (busy_i) state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!busy_i) begin
                    ct_load   = 1'b1;
                    state_nxt = TX_CT;
                end
            end
            TX_CT: begin
                if (tx_fire) begin
                    ct_shift = 1'b1;
                    cnt_inc  = 1'b1;
                    if (cnt == CNT_W'(CT_BYTES - 1)) state_nxt = CMD;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef AES_LOADER_TIMEOUT_EN
        // A core that finishes on the deadline cycle still wins over the abort.
        if (to_hit && (state == WAIT_HI || (state == WAIT_LO && busy_i))) begin
            state_nxt = CMD;
            err_set   = 1'b1;
        end
`endif
    end

    // Byte counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_o <= 1'b0;
            tx_valid_o <= 1'b0;
            load_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            rx_ready_o <= (state_nxt == CMD) || (state_nxt == RX_KEY) || (state_nxt == RX_PT);
            tx_valid_o <= (state_nxt == TX_CT);
            load_o     <= (state_nxt == LAUNCH);
            if (err_set) begin
                err_o <= 1'b1;
            end else if (err_clr) begin
                err_o <= 1'b0;
            end
        end
    end

    aes_loader_shreg #(.WIDTH(KEY_SR_W)) u_key_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (key_clr),
        .load      (1'b0),
        .load_data ('0),
        .shift     (key_shift),
        .din       (rx_data_i),
        .q         (key_q)
    );

    aes_loader_shreg #(.WIDTH(PT_W)) u_pt_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pt_clr),
        .load      (1'b0),
        .load_data ('0),
        .shift     (pt_shift),
        .din       (rx_data_i),
        .q         (pt_o)
    );

    aes_loader_shreg #(.WIDTH(CT_W)) u_ct_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (1'b0),
        .load      (ct_load),
        .load_data (ct_i),
        .shift     (ct_shift),
        .din       (8'h00),
        .q         (ct_q)
    );

    // Short keys occupy the top of key_o; the unused low bytes read as zero.
    assign key_o     = KEY_W'(key_q) << KEY_PAD;
    assign tx_data_o = ct_q[CT_W-1 -: BYTE_W];

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed self-checking bench for aes_byte_loader with a simple busy/ct model of the AES core.
module tb_aes_byte_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [255:0] key;
    logic [127:0] pt;
    logic         load;
    logic         busy;
    logic [127:0] ct;
    logic         err;

    int total  = 0;
    int passed = 0;
    int load_cnt = 0;

    typedef struct {
        logic [7:0] b;
        logic       exp_err;
    } cmd_vec_t;

    cmd_vec_t tbl[7];

    always #5 clk = ~clk;

    aes_byte_loader #(.KEY_BYTES(32), .TIMEOUT_CYC(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .key_o      (key),
        .pt_o       (pt),
        .load_o     (load),
        .busy_i     (busy),
        .ct_i       (ct),
        .err_o      (err)
    );

    always @(negedge clk) if (load) load_cnt++;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rx_ready) begin
                @(negedge clk);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        total++;
        $display("FAIL rx_timeout: byte %0h not accepted within 200 cycles", b);
    endtask

    task automatic recv_byte(input int idx, input logic [7:0] exp);
        tx_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_valid) begin
                check($sformatf("tx_byte%0d", idx), 256'(tx_data), 256'(exp));
                @(negedge clk);
                tx_ready = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        total++;
        $display("FAIL tx_timeout: byte %0d not offered within 200 cycles", idx);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] ct_a;
        logic [127:0] ct_b;
        logic [7:0]   eb;
        int           seen;

        tbl[0] = '{8'h55, 1'b1};
        tbl[1] = '{8'h63, 1'b0};
        tbl[2] = '{8'h00, 1'b1};
        tbl[3] = '{8'hFF, 1'b1};
        tbl[4] = '{8'h63, 1'b0};
        tbl[5] = '{8'h6A, 1'b1};
        tbl[6] = '{8'h55, 1'b1};

        ct_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct_b = 128'h00112233445566778899aabbccddeeff;

        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; busy = 1'b0; ct = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 256'({rx_ready, tx_valid, tx_data, load, err}), 256'(0));
        check("rst_key", key, 256'(0));
        check("rst_pt", 256'(pt), 256'(0));
        rst_n = 1'b1;

        // Key load
        send_byte(8'h6B);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        check("key_o", key,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        check("key_back_in_cmd", 256'(rx_ready), 256'(1));
        check("key_no_load", 256'(load_cnt), 256'(0));

        // Encrypt with rx gaps, busy model, tx back-pressure
        send_byte(8'h70);
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 1) repeat (2) @(negedge clk);
            send_byte(8'(i * 17));
        end
        check("pt_o", 256'(pt), 256'(128'h00112233445566778899aabbccddeeff));
        check("load_latency", 256'(load), 256'(1));
        check("rx_held_off", 256'(rx_ready), 256'(0));
        busy = 1'b1;
        ct   = ct_a;
        repeat (20) @(negedge clk);
        check("no_tx_while_busy", 256'(tx_valid), 256'(0));
        busy = 1'b0;
        @(negedge clk);
        check("tx_valid_latency", 256'(tx_valid), 256'(1));
        for (int i = 0; i < 16; i++) begin
            eb = ct_a[127 - 8*i -: 8];
            if (i == 7) begin
                tx_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check($sformatf("stall_data%0d", s), 256'({tx_valid, tx_data}), 256'({1'b1, eb}));
                    @(negedge clk);
                end
            end
            recv_byte(i, eb);
        end
        check("tx_done_valid", 256'(tx_valid), 256'(0));
        check("one_load_pulse", 256'(load_cnt), 256'(1));
        check("rx_after_tx", 256'(rx_ready), 256'(1));

        // Command table: error set/clear behaviour
        for (int i = 0; i < 7; i++) begin
            send_byte(tbl[i].b);
            check($sformatf("cmd%0d_err", i), 256'(err), 256'(tbl[i].exp_err));
            check($sformatf("cmd%0d_ready", i), 256'(rx_ready), 256'(1));
        end

        // Async reset while waiting for busy to fall
        send_byte(8'h70);
        for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i));
        busy = 1'b1;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 256'({rx_ready, tx_valid, tx_data, load, err}), 256'(0));
        check("mid_rst_key", key, 256'(0));
        check("mid_rst_pt", 256'(pt), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        busy  = 1'b0;
        seen  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid) seen++;
        end
        check("no_tx_after_rst", 256'(seen), 256'(0));

        // Fresh encrypt after reset
        load_cnt = 0;
        send_byte(8'h70);
        for (int i = 0; i < 16; i++) send_byte(8'hF0 - 8'(i));
        check("pt2_o", 256'(pt), 256'(128'hf0efeeedecebeae9e8e7e6e5e4e3e2e1));
        check("load2", 256'(load), 256'(1));
        busy = 1'b1;
        ct   = ct_b;
        repeat (3) @(negedge clk);
        busy = 1'b0;
        for (int i = 0; i < 16; i++) recv_byte(i + 16, ct_b[127 - 8*i -: 8]);
        check("tx2_done_valid", 256'(tx_valid), 256'(0));
        check("load2_count", 256'(load_cnt), 256'(1));

`ifdef AES_LOADER_TIMEOUT_EN
        // Core never finishes: loader must abort, flag an error and return to CMD
        send_byte(8'h63);
        send_byte(8'h70);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        busy = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx_valid) seen++;
        end
        check("to_err", 256'(err), 256'(1));
        check("to_no_tx", 256'(seen), 256'(0));
        check("to_ready", 256'(rx_ready), 256'(1));
        busy = 1'b0;
        send_byte(8'h63);
        check("to_clear", 256'(err), 256'(0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
